accum_rr_sched: RTL and testbench

//  Round-robin scheduler sharing one Accum1D accumulator between NUM_REQ requesters.

---
 rtl/accum_rr_sched.sv | 156 +++++++++++++++
 tb/tb_accum_rr_sched.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/accum_rr_sched.sv
// Round-robin scheduler that shares one Accum1D accumulator between NUM_REQ requesters.
// Walks each grant through the accumulator's en/done handshake and returns the post-add value.
module accum_rr_sched #(
    parameter int NUM_REQ     = 4,
    parameter int ADD_WIDTH   = 32,
    parameter int ACCUM_WIDTH = 64,
    parameter int TIMEOUT     = 16
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ*ADD_WIDTH-1:0]   req_add,
    output logic [NUM_REQ-1:0]             req_ack,
    output logic [ACCUM_WIDTH-1:0]         result,
    output logic [NUM_REQ-1:0]             grant,
    output logic                           busy,
    input  logic                           clr_req,
    output logic                           err,
    input  logic                           err_clr,
    output logic                           acc_reset_l,
    output logic                           acc_en,
    output logic [ADD_WIDTH-1:0]           acc_add,
    input  logic [ACCUM_WIDTH-1:0]         acc_accum,
    input  logic                           acc_done
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, CLEAR, WAIT_DONE, WAIT_REL, ACK} state_t;

    state_t                 state, state_nxt;
    logic [PW-1:0]          ptr, ptr_nxt;
    logic [PW-1:0]          gidx, gidx_nxt;
    logic [TW-1:0]          tcnt, tcnt_nxt;
    logic [NUM_REQ-1:0]     grant_nxt, req_ack_nxt;
    logic [ACCUM_WIDTH-1:0] result_nxt;
    logic                   err_nxt, acc_en_nxt, acc_reset_l_nxt;
    logic                   pick_found;
    logic [PW-1:0]          pick_idx;
    logic                   timeout;

    // First requester at or above ptr, wrapping around.
    always_comb begin : pick
        int unsigned j;
        j          = 0;
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            j = 32'(ptr) + k;
            if (j >= NUM_REQ) j = j - NUM_REQ;
            if (!pick_found && req_valid[PW'(j)]) begin
                pick_found = 1'b1;
                pick_idx   = PW'(j);
            end
        end
    end

    always_comb begin
        acc_add = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) acc_add = req_add[i*ADD_WIDTH +: ADD_WIDTH];
        end
    end

    assign timeout = (tcnt == TW'(TIMEOUT - 1));

    always_comb begin
        state_nxt       = state;
        ptr_nxt         = ptr;
        gidx_nxt        = gidx;
        tcnt_nxt        = '0;
        grant_nxt       = grant;
        req_ack_nxt     = '0;
        result_nxt      = result;
        err_nxt         = err & ~err_clr;
        acc_en_nxt      = acc_en;
        acc_reset_l_nxt = 1'b1;
        case (state)
            IDLE: begin
                if (clr_req) begin
                    acc_reset_l_nxt = 1'b0;
                    state_nxt       = CLEAR;
                end else if (pick_found) begin
                    grant_nxt  = NUM_REQ'(1) << pick_idx;
                    gidx_nxt   = pick_idx;
                    acc_en_nxt = 1'b1;
                    state_nxt  = WAIT_DONE;
                end
            end
            CLEAR: state_nxt = IDLE;
            WAIT_DONE: begin
                if (acc_done) begin
                    result_nxt = acc_accum;
                    acc_en_nxt = 1'b0;
                    state_nxt  = WAIT_REL;
                end else if (timeout) begin
                    err_nxt     = 1'b1;
                    acc_en_nxt  = 1'b0;
                    req_ack_nxt = grant;
                    state_nxt   = ACK;
                end else begin
                    tcnt_nxt = tcnt + 1'b1;
                end
            end
            WAIT_REL: begin
                if (!acc_done) begin
                    req_ack_nxt = grant;
                    state_nxt   = ACK;
                end else if (timeout) begin
                    err_nxt     = 1'b1;
                    acc_en_nxt  = 1'b0;
                    req_ack_nxt = grant;
                    state_nxt   = ACK;
                end else begin
                    tcnt_nxt = tcnt + 1'b1;
                end
            end
            ACK: begin
                grant_nxt = '0;
                ptr_nxt   = (gidx == PW'(NUM_REQ - 1)) ? '0 : gidx + 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            ptr         <= '0;
            gidx        <= '0;
            tcnt        <= '0;
            grant       <= '0;
            req_ack     <= '0;
            result      <= '0;
            err         <= 1'b0;
            acc_en      <= 1'b0;
            acc_reset_l <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= state_nxt;
            ptr         <= ptr_nxt;
            gidx        <= gidx_nxt;
            tcnt        <= tcnt_nxt;
            grant       <= grant_nxt;
            req_ack     <= req_ack_nxt;
            result      <= result_nxt;
            err         <= err_nxt;
            acc_en      <= acc_en_nxt;
            acc_reset_l <= acc_reset_l_nxt;
            busy        <= (state_nxt != IDLE);
        end
    end

endmodule

// File: tb/tb_accum_rr_sched.sv
// Bench for accum_rr_sched: vector table, directed corner sequences and a randomized run
// scored against a transaction-level round-robin/accumulation model.
module tb_accum_rr_sched;

    localparam int NR = 4;
    localparam int AW = 4;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic [NR-1:0] req_valid;
    logic [NR*AW-1:0] req_add;
    logic [NR-1:0] req_ack;
    logic [CW-1:0] result;
    logic [NR-1:0] grant;
    logic          busy;
    logic          clr_req;
    logic          err;
    logic          err_clr;
    logic          acc_reset_l;
    logic          acc_en;
    logic [AW-1:0] acc_add;
    logic [CW-1:0] acc_accum;
    logic          acc_done;

    always #5 clk = ~clk;

    accum_rr_sched #(.NUM_REQ(NR), .ADD_WIDTH(AW), .ACCUM_WIDTH(CW), .TIMEOUT(16)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_add(req_add),
        .req_ack(req_ack), .result(result), .grant(grant), .busy(busy),
        .clr_req(clr_req), .err(err), .err_clr(err_clr), .acc_reset_l(acc_reset_l),
        .acc_en(acc_en), .acc_add(acc_add), .acc_accum(acc_accum), .acc_done(acc_done)
    );

    // Accumulator stand-in: done follows en after acc_lat extra cycles; stall withholds done.
    logic [CW-1:0] m_accum = '0;
    logic          m_done  = 1'b0;
    int            m_wcnt  = 0;
    int            acc_lat = 0;
    bit            stall   = 1'b0;
    assign acc_accum = m_accum;
    assign acc_done  = m_done;

    always @(posedge clk) begin
        if (acc_reset_l === 1'b0) begin
            m_accum <= '0; m_done <= 1'b0; m_wcnt <= 0;
        end else if (acc_en === 1'b1 && !m_done) begin
            if (!stall) begin
                if (m_wcnt >= acc_lat) begin
                    m_accum <= m_accum + CW'(acc_add); m_done <= 1'b1; m_wcnt <= 0;
                end else m_wcnt <= m_wcnt + 1;
            end
        end else if (acc_en === 1'b0 && m_done) begin
            if (m_wcnt >= acc_lat) begin m_done <= 1'b0; m_wcnt <= 0; end
            else m_wcnt <= m_wcnt + 1;
        end
    end

    int total = 0;
    int bad   = 0;
    int            ack_log_idx[$];
    logic [CW-1:0] ack_log_res[$];
    bit            ack_seen;
    int            ack_idx;
    logic [NR-1:0] rerequest, reraise;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // One clock: sample at negedge, log any ack, and behave like well-mannered requesters.
    task automatic cycle();
        @(negedge clk);
        ack_seen = 1'b0;
        if (req_ack != '0) begin
            ack_seen = 1'b1;
            chk("ack_onehot", $countones(req_ack), 1);
            for (int i = 0; i < NR; i++) if (req_ack[i]) ack_idx = i;
            ack_log_idx.push_back(ack_idx);
            ack_log_res.push_back(result);
            req_valid[ack_idx] = 1'b0;
            reraise[ack_idx]   = rerequest[ack_idx];
        end else begin
            for (int i = 0; i < NR; i++)
                if (reraise[i]) begin req_valid[i] = 1'b1; reraise[i] = 1'b0; end
        end
    endtask

    task automatic wait_acks(input int n, input int budget, input string name);
        int c = 0;
        while (ack_log_idx.size() < n && c < budget) begin cycle(); c++; end
        chk({name, "_nacks"}, ack_log_idx.size(), n);
    endtask

    task automatic reset_dut();
        reset = 1'b1; req_valid = '0; req_add = '0; clr_req = 1'b0; err_clr = 1'b0;
        stall = 1'b0; acc_lat = 0; rerequest = '0; reraise = '0;
        ack_log_idx.delete(); ack_log_res.delete();
        @(negedge clk); @(negedge clk);
        chk("rst_grant", grant, 0);
        chk("rst_ack", req_ack, 0);
        chk("rst_result", result, 0);
        chk("rst_err", err, 0);
        chk("rst_acc_en", acc_en, 0);
        chk("rst_acc_reset_l", acc_reset_l, 0);
        chk("rst_busy", busy, 0);
        reset = 1'b0;
        cycle();
    endtask

    function automatic int rr_pick(input logic [NR-1:0] v, input int p);
        for (int k = 0; k < NR; k++) if (v[(p + k) % NR]) return (p + k) % NR;
        return -1;
    endfunction

    typedef struct {
        logic [NR-1:0]    mask;
        logic [NR*AW-1:0] adds;
        int               n;
        logic [7:0]       ord;   // 2-bit requester index per ack, first ack in [1:0]
        logic [31:0]      res;   // result byte per ack, first ack in [7:0]
    } vec_t;

    vec_t vecs[5];

    initial begin
        int            mptr, mwin, nacks_r;
        logic [CW-1:0] msum;
        logic [AW-1:0] madd [NR];
        logic [NR-1:0] prev_valid, last_grant;
        logic [7:0]    ord;
        logic [31:0]   res;
        bit            found;

        vecs[0] = '{mask: 4'b0001, adds: 16'h0005, n: 1, ord: 8'h00, res: 32'h00000005};
        vecs[1] = '{mask: 4'b1111, adds: 16'h4321, n: 4, ord: 8'hE4, res: 32'h0A060301};
        vecs[2] = '{mask: 4'b1010, adds: 16'h9070, n: 2, ord: 8'h0D, res: 32'h00001007};
        vecs[3] = '{mask: 4'b1000, adds: 16'hF000, n: 1, ord: 8'h03, res: 32'h0000000F};
        vecs[4] = '{mask: 4'b0110, adds: 16'h0FF0, n: 2, ord: 8'h09, res: 32'h00001E0F};

        foreach (vecs[v]) begin
            reset_dut();
            req_add = vecs[v].adds; req_valid = vecs[v].mask;
            wait_acks(vecs[v].n, 300, "vec");
            ord = vecs[v].ord; res = vecs[v].res;
            for (int k = 0; k < vecs[v].n; k++) begin
                if (k < ack_log_idx.size()) begin
                    chk("vec_order", ack_log_idx[k], 32'(ord[2*k +: 2]));
                    chk("vec_result", ack_log_res[k], 32'(res[8*k +: 8]));
                end
            end
            cycle();
            chk("vec_idle_busy", busy, 0);
        end

        // Single add latency with an ideal accumulator
        reset_dut();
        req_add[3:0] = 4'd5; req_valid = 4'b0001;
        for (int c = 1; c <= 6; c++) begin
            cycle();
            case (c)
                1: begin chk("lat_en_c1", acc_en, 1); chk("lat_grant", grant, 4'b0001);
                         chk("lat_busy", busy, 1); chk("lat_acc_add", acc_add, 5); end
                2: chk("lat_en_c2", acc_en, 1);
                3: chk("lat_en_c3", acc_en, 0);
                4: chk("lat_noack_c4", req_ack, 0);
                5: begin chk("lat_ack_c5", req_ack, 4'b0001); chk("lat_result", result, 5); end
                default: begin chk("lat_ack_c6", req_ack, 0); chk("lat_grant_c6", grant, 0); end
            endcase
        end

        // Fairness between two continuous requesters
        reset_dut();
        rerequest = 4'b0101; req_add = 16'h0101; req_valid = 4'b0101;
        wait_acks(4, 200, "fair");
        for (int k = 0; k < 4 && k < ack_log_idx.size(); k++)
            chk("fair_order", ack_log_idx[k], (k % 2 == 0) ? 0 : 2);
        rerequest = '0;

        // Clear takes priority over a pending request
        reset_dut();
        req_add[3:0] = 4'd10; req_valid = 4'b0001;
        wait_acks(1, 50, "clr_pre");
        chk("clr_pre_result", result, 10);
        cycle();
        clr_req = 1'b1; req_add[7:4] = 4'd7; req_valid[1] = 1'b1;
        cycle();
        chk("clr_reset_l_low", acc_reset_l, 0);
        chk("clr_no_grant", grant, 0);
        clr_req = 1'b0;
        cycle();
        chk("clr_reset_l_high", acc_reset_l, 1);
        chk("clr_still_no_grant", grant, 0);
        wait_acks(2, 50, "clr_post");
        if (ack_log_idx.size() >= 2) begin
            chk("clr_post_idx", ack_log_idx[1], 1);
            chk("clr_post_result", ack_log_res[1], 7);
        end

        // Timeout with a stalled accumulator, then err_clr, then set-wins-over-clear
        reset_dut();
        req_add[3:0] = 4'd6; req_valid = 4'b0001;
        wait_acks(1, 50, "to_pre");
        cycle();
        stall = 1'b1; req_add[7:4] = 4'd3; req_valid[1] = 1'b1;
        for (int c = 1; c <= 17; c++) begin
            cycle();
            if (c == 1)  chk("to_en_c1", acc_en, 1);
            if (c == 16) begin chk("to_err_c16", err, 0); chk("to_en_c16", acc_en, 1);
                               chk("to_noack_c16", req_ack, 0); end
            if (c == 17) begin chk("to_err_c17", err, 1); chk("to_ack_c17", req_ack, 4'b0010);
                               chk("to_en_c17", acc_en, 0); chk("to_result_kept", result, 6); end
        end
        cycle();
        chk("to_err_sticky", err, 1);
        err_clr = 1'b1;
        cycle();
        chk("to_err_cleared", err, 0);
        req_add[11:8] = 4'd1; req_valid[2] = 1'b1;
        for (int c = 1; c <= 17; c++) cycle();
        chk("to2_ack", req_ack, 4'b0100);
        chk("to2_set_wins", err, 1);
        cycle();
        chk("to2_err_cleared", err, 0);
        err_clr = 1'b0; stall = 1'b0;

        // Reset in WAIT_REL abandons the add and returns the pointer to 0
        reset_dut();
        req_add[3:0] = 4'd2; req_valid = 4'b0001;
        wait_acks(1, 50, "rm_pre");
        cycle();
        req_add[11:8] = 4'd4; req_valid[2] = 1'b1;
        found = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            cycle();
            if (grant == 4'b0100 && acc_en == 1'b0) found = 1'b1;
        end
        chk("rm_reached_wait_rel", found, 1);
        reset = 1'b1;
        @(negedge clk);
        chk("rm_grant", grant, 0);
        chk("rm_acc_en", acc_en, 0);
        chk("rm_acc_reset_l", acc_reset_l, 0);
        chk("rm_no_ack", req_ack, 0);
        chk("rm_busy", busy, 0);
        reset = 1'b0; req_valid = '0;
        cycle();
        chk("rm_no_late_ack", ack_log_idx.size(), 1);
        req_add = 16'h5003; req_valid = 4'b1001;
        wait_acks(2, 50, "rm_post");
        if (ack_log_idx.size() >= 2) begin
            chk("rm_ptr_zero", ack_log_idx[1], 0);
            chk("rm_result", ack_log_res[1], 3);
        end

        // Accumulator wrap: fifteen adds of 0xF
        reset_dut();
        for (int k = 1; k <= 15; k++) begin
            req_add[3:0] = 4'hF; req_valid[0] = 1'b1;
            wait_acks(k, 50, "wrap");
            chk("wrap_step", result, (15 * k) % 256);
            cycle();
        end
        chk("wrap_final", result, 8'hE1);

        // Randomized traffic against the round-robin model
        reset_dut();
        mptr = 0; mwin = -1; nacks_r = 0; msum = '0;
        prev_valid = '0; last_grant = '0;
        foreach (madd[i]) madd[i] = '0;
        for (int c = 0; c < 600; c++) begin
            cycle();
            if (grant != '0 && last_grant == '0) begin
                mwin = rr_pick(prev_valid, mptr);
                chk("rnd_grant", grant, (mwin < 0) ? 32'hFFFF : (32'd1 << mwin));
            end
            last_grant = grant;
            if (ack_seen) begin
                if (mwin >= 0) msum = msum + CW'(madd[mwin]);
                chk("rnd_ack_idx", ack_idx, mwin);
                chk("rnd_result", ack_log_res[ack_log_res.size()-1], msum);
                if (mwin >= 0) mptr = (mwin + 1) % NR;
                nacks_r++;
            end
            for (int i = 0; i < NR; i++) begin
                if (!req_valid[i] && !(ack_seen && ack_idx == i) && $urandom_range(3) == 0) begin
                    madd[i] = AW'($urandom_range(15));
                    req_add[i*AW +: AW] = madd[i];
                    req_valid[i] = 1'b1;
                end
            end
            if ($urandom_range(7) == 0) acc_lat = $urandom_range(3);
            prev_valid = req_valid;
        end
        chk("rnd_activity", nacks_r > 20, 1);
        chk("rnd_no_err", err, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
